// File: rtl/if_id_reg_pkg.sv
// Shared core definitions: exception codes, fixed addresses and the D-stage bundle.
package if_id_reg_pkg;

  typedef logic [4:0] exc_t;

  localparam exc_t        EXC_NONE        = 5'd0;
  localparam exc_t        EXC_ADEL        = 5'd4;

  localparam logic [31:0] CORE_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] CORE_HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] CORE_NOP_INSTR  = 32'h0000_0000;

  // Decode-stage contents; later stage registers carry the same fields forward.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    exc_t        exccode;
    logic        bd;
    logic        valid;
  } d_bundle_t;

  // Empty slot: nop word, no fault, not a delay slot, not valid.
  function automatic d_bundle_t d_bubble(input logic [31:0] nop, input logic [31:0] pc);
    d_bundle_t b;
    b.instr   = nop;
    b.pc      = pc;
    b.exccode = EXC_NONE;
    b.bd      = 1'b0;
    b.valid   = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/if_id_reg_if.sv
// Fetch-to-decode bus: F-side inputs, D-side outputs and the stage counters.
interface if_id_reg_if
  import if_id_reg_pkg::*;
#(
  parameter int CNT_W = 32
);
  logic             en;
  logic             IntReq;
  logic             eret;
  logic             bd_F;
  logic [31:0]      instr_F;
  logic [31:0]      PC_F;
  exc_t             exccode_F;

  logic [31:0]      instr_D;
  logic [31:0]      PC_D;
  exc_t             exccode_D;
  logic             bd_D;
  logic             valid_D;
  logic [CNT_W-1:0] fetch_count;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output en, IntReq, eret, bd_F, instr_F, PC_F, exccode_F,
    input  instr_D, PC_D, exccode_D, bd_D, valid_D, fetch_count, stall_count
  );

  modport slave (
    input  en, IntReq, eret, bd_F, instr_F, PC_F, exccode_F,
    output instr_D, PC_D, exccode_D, bd_D, valid_D, fetch_count, stall_count
  );
endinterface

// File: rtl/if_id_reg_sat_counter.sv
// Saturating up-counter: +1 per cycle when inc is high, sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up, never wrap past all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 count <= '0;
    else if (inc && ~&count)    count <= count + 1'b1;
  end

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: stall hold, flush-to-bubble, nop for faulting fetches,
// plus saturating counters for accepted fetches and held-valid stall cycles.
module if_id_reg
  import if_id_reg_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = CORE_RESET_PC,
  parameter logic [31:0] NOP_INSTR = CORE_NOP_INSTR,
  parameter int          CNT_W     = 32
) (
  input  logic         clk,
  input  logic         reset,
  if_id_reg_if.slave   bus
);

  d_bundle_t d_q, d_nxt;
  logic      flush, load, stall_hit;

  // Flush beats stall beats load; a held bubble is not a stall worth counting.
  assign flush     = bus.IntReq | bus.eret;
  assign load      = bus.en & ~flush;
  assign stall_hit = ~bus.en & ~flush & d_q.valid;

  // Next D-stage contents.
  always_comb begin
    d_nxt = d_q;
    if (flush) begin
      d_nxt = d_bubble(NOP_INSTR, 32'h0);
    end else if (bus.en) begin
      d_nxt.pc      = bus.PC_F;
      d_nxt.bd      = bus.bd_F;
      d_nxt.exccode = bus.exccode_F;
      d_nxt.valid   = 1'b1;
      // A faulting fetch must not act downstream; PC still travels for EPC.
      d_nxt.instr   = (bus.exccode_F != EXC_NONE) ? NOP_INSTR : bus.instr_F;
    end
  end

  // Stage register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) d_q <= d_bubble(NOP_INSTR, RESET_PC);
    else        d_q <= d_nxt;
  end

  assign bus.instr_D   = d_q.instr;
  assign bus.PC_D      = d_q.pc;
  assign bus.exccode_D = d_q.exccode;
  assign bus.bd_D      = d_q.bd;
  assign bus.valid_D   = d_q.valid;

  sat_counter #(.W(CNT_W)) u_fetch_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (load),
    .count (bus.fetch_count)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_hit),
    .count (bus.stall_count)
  );

endmodule

// File: tb/tb_if_id_reg.sv
// Bench for if_id_reg: directed walk-through plus random traffic against a
// reference model; a second 4-bit-counter build shares the stimulus to reach saturation.
module tb_if_id_reg;
  localparam logic [31:0] T_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] T_NOP      = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  if_id_reg_if #(.CNT_W(32)) b32 ();
  if_id_reg_if #(.CNT_W(4))  b4  ();

  assign b4.en        = b32.en;
  assign b4.IntReq    = b32.IntReq;
  assign b4.eret      = b32.eret;
  assign b4.bd_F      = b32.bd_F;
  assign b4.instr_F   = b32.instr_F;
  assign b4.PC_F      = b32.PC_F;
  assign b4.exccode_F = b32.exccode_F;

  if_id_reg #(.CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(b32));
  if_id_reg #(.CNT_W(4))  dut4 (.clk(clk), .reset(reset), .bus(b4));

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state, updated from the behavioural rules.
  logic [31:0] m_instr, m_pc;
  logic [4:0]  m_exc;
  logic        m_bd, m_valid;
  longint      m_fetch, m_stall;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_instr = T_NOP; m_pc = T_RESET_PC; m_exc = 5'd0; m_bd = 1'b0; m_valid = 1'b0;
    m_fetch = 0; m_stall = 0;
  endtask

  task automatic check_all();
    chk("instr_D",   {32'h0, b32.instr_D},      {32'h0, m_instr});
    chk("PC_D",      {32'h0, b32.PC_D},         {32'h0, m_pc});
    chk("exccode_D", {59'h0, b32.exccode_D},    {59'h0, m_exc});
    chk("bd_D",      {63'h0, b32.bd_D},         {63'h0, m_bd});
    chk("valid_D",   {63'h0, b32.valid_D},      {63'h0, m_valid});
    chk("fetch_cnt", {32'h0, b32.fetch_count},  64'(m_fetch));
    chk("stall_cnt", {32'h0, b32.stall_count},  64'(m_stall));
    chk("fetch_cnt4", {60'h0, b4.fetch_count},  (m_fetch > 15) ? 64'd15 : 64'(m_fetch));
    chk("stall_cnt4", {60'h0, b4.stall_count},  (m_stall > 15) ? 64'd15 : 64'(m_stall));
  endtask

  // One cycle: drive at the falling edge, update model at the rising edge, check at the next fall.
  task automatic cyc(input logic en, input logic irq, input logic er, input logic bd,
                     input logic [31:0] instr, input logic [31:0] pc, input logic [4:0] exc);
    b32.en = en; b32.IntReq = irq; b32.eret = er; b32.bd_F = bd;
    b32.instr_F = instr; b32.PC_F = pc; b32.exccode_F = exc;
    #1 chk("no_comb_path", {32'h0, b32.PC_D}, {32'h0, m_pc});
    @(posedge clk);
    if (irq || er) begin
      m_instr = T_NOP; m_pc = 32'h0; m_exc = 5'd0; m_bd = 1'b0; m_valid = 1'b0;
    end else if (!en) begin
      if (m_valid) m_stall++;
    end else begin
      m_pc = pc; m_bd = bd; m_exc = exc; m_valid = 1'b1;
      m_instr = (exc != 5'd0) ? T_NOP : instr;
      m_fetch++;
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    reset = 1'b0;
    b32.en = 1'b0; b32.IntReq = 1'b0; b32.eret = 1'b0; b32.bd_F = 1'b0;
    b32.instr_F = '0; b32.PC_F = '0; b32.exccode_F = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    reset = 1'b1;

    // First load after reset.
    cyc(1, 0, 0, 0, 32'h2408_0005, 32'h3000, 5'd0);
    // Stall three cycles with changing fetch data.
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, $urandom, $urandom, 5'd0);
    // Faulting fetch becomes a nop but keeps its PC and code.
    cyc(1, 0, 0, 0, 32'h8C01_0000, 32'h3002, 5'd4);
    // Stalled valid instruction, then interrupt flush while still stalled.
    cyc(0, 0, 0, 0, 32'h1111_1111, 32'h3004, 5'd0);
    cyc(0, 1, 0, 0, 32'h2222_2222, 32'h3008, 5'd4);
    // Stall on a bubble is not counted.
    cyc(0, 0, 0, 0, 32'h3333_3333, 32'h300C, 5'd0);
    // Delay-slot load, then eret flush.
    cyc(1, 0, 0, 1, 32'h0000_0020, 32'h3010, 5'd0);
    cyc(1, 0, 1, 1, 32'h0000_0024, 32'h3014, 5'd0);
    // Faulting delay-slot instruction; then both flush sources at once.
    cyc(1, 0, 0, 1, 32'hDEAD_BEEF, 32'h3019, 5'd4);
    cyc(1, 1, 1, 0, 32'h1234_5678, 32'h3020, 5'd0);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      cyc(($urandom_range(3) != 0), ($urandom_range(15) == 0), ($urandom_range(15) == 0),
          1'($urandom), $urandom, $urandom,
          ($urandom_range(7) == 0) ? 5'd4 : 5'd0);
    end
    // Guarantee the small counters sit at saturation, then one more of each.
    for (int i = 0; i < 16; i++) cyc(1, 0, 0, 0, $urandom, $urandom, 5'd0);
    for (int i = 0; i < 17; i++) cyc(0, 0, 0, 0, $urandom, $urandom, 5'd0);
    cyc(1, 0, 0, 0, 32'h0000_0001, 32'h4180, 5'd0);

    // Asynchronous reset mid-stall, between clock edges.
    b32.en = 1'b0;
    #2 reset = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    check_all();
    reset = 1'b1;
    cyc(1, 0, 0, 0, 32'h2408_0005, 32'h3000, 5'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
